// File: rtl/mem_stage_if.sv
// Word-memory bus between mem_stage (master) and a variable-latency memory (slave).
// A request is held until the cycle in which mem_ack_in is high.
interface mem_stage_if;
    logic        mem_req_out;
    logic        mem_we_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_wdata_out;
    logic [31:0] mem_rdata_in;
    logic        mem_ack_in;

    modport master (
        output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
        input  mem_rdata_in, mem_ack_in
    );

    modport slave (
        input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
        output mem_rdata_in, mem_ack_in
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: one ALU result at a time, lw/lb/sw/sb against a req/ack word memory,
// byte stores done as read-modify-write, registered writeback packet with timeout abort.
module mem_stage #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [31:0] alu_mem_addr_in,
    input  logic [31:0] alu_data_in,
    input  logic [4:0]  alu_reg_num_in,
    input  logic        alu_reg_enable_in,
    input  logic        alu_lw_in,
    input  logic        alu_lb_in,
    input  logic        alu_sw_in,
    input  logic        alu_sb_in,
    mem_stage_if.master mem,
    output logic        wb_valid_out,
    output logic        wb_reg_enable_out,
    output logic [4:0]  wb_reg_num_out,
    output logic [31:0] wb_data_out,
    output logic        misaligned_out,
    output logic        mem_error_out
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, WB} state_t;
    typedef enum logic [2:0] {OP_NONE, OP_LW, OP_LB, OP_SW, OP_SB} op_t;

    state_t        state;
    op_t           op_in, op_q;
    logic [1:0]    lane_q;
    logic [7:0]    byte_q;
    logic [4:0]    reg_num_q;
    logic          reg_en_q;
    logic          misal_q;
    logic [CW-1:0] cnt;

    logic [4:0]    lane_sh;
    logic [7:0]    rd_byte;
    logic [31:0]   merged;
    logic          timed_out;
    logic          is_load;

    always_comb begin
        op_in = OP_NONE;
        if (alu_lw_in)      op_in = OP_LW;
        else if (alu_lb_in) op_in = OP_LB;
        else if (alu_sw_in) op_in = OP_SW;
        else if (alu_sb_in) op_in = OP_SB;
    end

    // Big-endian lanes: lane 0 is bits [31:24], so shift by (3 - lane) bytes.
    assign lane_sh   = {~lane_q, 3'b000};
    assign rd_byte   = 8'(mem.mem_rdata_in >> lane_sh);
    assign merged    = (mem.mem_rdata_in & ~(32'hFF << lane_sh)) | ({24'h0, byte_q} << lane_sh);
    assign timed_out = !mem.mem_ack_in && (cnt == CW'(TIMEOUT - 1));
    assign is_load   = (op_q == OP_LW) || (op_q == OP_LB);

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state             <= IDLE;
            ready_out         <= 1'b1;
            op_q              <= OP_NONE;
            lane_q            <= '0;
            byte_q            <= '0;
            reg_num_q         <= '0;
            reg_en_q          <= 1'b0;
            misal_q           <= 1'b0;
            cnt               <= '0;
            mem.mem_req_out   <= 1'b0;
            mem.mem_we_out    <= 1'b0;
            mem.mem_addr_out  <= '0;
            mem.mem_wdata_out <= '0;
            wb_valid_out      <= 1'b0;
            wb_reg_enable_out <= 1'b0;
            wb_reg_num_out    <= '0;
            wb_data_out       <= '0;
            misaligned_out    <= 1'b0;
            mem_error_out     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (valid_in) begin
                    ready_out        <= 1'b0;
                    cnt              <= '0;
                    op_q             <= op_in;
                    lane_q           <= alu_mem_addr_in[1:0];
                    byte_q           <= alu_data_in[7:0];
                    reg_num_q        <= alu_reg_num_in;
                    reg_en_q         <= alu_reg_enable_in;
                    misal_q          <= ((op_in == OP_LW) || (op_in == OP_SW)) &&
                                        (alu_mem_addr_in[1:0] != 2'b00);
                    mem.mem_addr_out <= {alu_mem_addr_in[31:2], 2'b00};
                    case (op_in)
                        OP_LW, OP_LB: begin
                            state           <= RD;
                            mem.mem_req_out <= 1'b1;
                            mem.mem_we_out  <= 1'b0;
                        end
                        OP_SW: begin
                            state             <= WR;
                            mem.mem_req_out   <= 1'b1;
                            mem.mem_we_out    <= 1'b1;
                            mem.mem_wdata_out <= alu_data_in;
                        end
                        OP_SB: begin
                            state           <= RMW_RD;
                            mem.mem_req_out <= 1'b1;
                            mem.mem_we_out  <= 1'b0;
                        end
                        default: begin
                            state             <= WB;
                            wb_valid_out      <= 1'b1;
                            wb_data_out       <= alu_data_in;
                            wb_reg_num_out    <= alu_reg_num_in;
                            wb_reg_enable_out <= alu_reg_enable_in && (alu_reg_num_in != 5'd0);
                            misaligned_out    <= 1'b0;
                            mem_error_out     <= 1'b0;
                        end
                    endcase
                end
                RD, WR, RMW_RD, RMW_WR: begin
                    if (mem.mem_ack_in && state == RMW_RD) begin
                        state             <= RMW_WR;
                        cnt               <= '0;
                        mem.mem_we_out    <= 1'b1;
                        mem.mem_wdata_out <= merged;
                    end else if (mem.mem_ack_in || timed_out) begin
                        // Same-cycle ack beats the timeout, so error is simply "no ack".
                        state             <= WB;
                        cnt               <= '0;
                        mem.mem_req_out   <= 1'b0;
                        mem.mem_we_out    <= 1'b0;
                        wb_valid_out      <= 1'b1;
                        wb_reg_num_out    <= reg_num_q;
                        misaligned_out    <= misal_q;
                        mem_error_out     <= !mem.mem_ack_in;
                        wb_reg_enable_out <= mem.mem_ack_in && is_load && reg_en_q &&
                                             (reg_num_q != 5'd0);
                        if (mem.mem_ack_in && op_q == OP_LW) wb_data_out <= mem.mem_rdata_in;
                        if (mem.mem_ack_in && op_q == OP_LB) wb_data_out <= {{24{rd_byte[7]}}, rd_byte};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WB: begin
                    state          <= IDLE;
                    ready_out      <= 1'b1;
                    wb_valid_out   <= 1'b0;
                    misaligned_out <= 1'b0;
                    mem_error_out  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage placed directly downstream of the execute ALU. Accepts one retired ALU result per handshake, performs the load/store it describes against a single-port, variable-latency word memory (req/ack), and produces a registered writeback packet for the register file. Byte loads are sign-extended. Byte stores use an internal read-modify-write sequence.

## Interface
- `TIMEOUT`, default 64: maximum cycles to wait for `mem_ack_in` before aborting the access.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_b` input 1: synchronous, active-high reset.
- `valid_in` input 1: an ALU result is presented.
- `ready_out` output 1: stage can accept. High only in IDLE.
- `alu_mem_addr_in` input 32: byte address from ALU.
- `alu_data_in` input 32: store data (sw/sb), or result data (non-memory ops).
- `alu_reg_num_in` input 5: destination register.
- `alu_reg_enable_in` input 1: destination write enable from ALU.
- `alu_lw_in`, `alu_lb_in`, `alu_sw_in`, `alu_sb_in` input 1 each: operation flags.
- `mem_req_out` output 1: memory request, held until ack.
- `mem_we_out` output 1: write request.
- `mem_addr_out` output 32: word address, bits [1:0] forced to 0.
- `mem_wdata_out` output 32: write data.
- `mem_rdata_in` input 32: read data, valid when `mem_ack_in`=1.
- `mem_ack_in` input 1: completes the current request.
- `wb_valid_out` output 1: one-cycle pulse per retired instruction.
- `wb_reg_enable_out` output 1: register write enable.
- `wb_reg_num_out` output 5: destination register.
- `wb_data_out` output 32: writeback data.
- `misaligned_out` output 1: pulses with `wb_valid_out` when lw/sw has addr[1:0]≠0.
- `mem_error_out` output 1: pulses with `wb_valid_out` on timeout. Sticky copy is not kept.

## Operation
- Reset: state IDLE. All outputs 0 except `ready_out`=1. Timeout counter cleared. An in-flight access is abandoned with no writeback.
- Accept: `valid_in & ready_out`. Inputs are latched into a request register.
- Flag priority when several are set: lw > lb > sw > sb.
- FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, WB.
  - IDLE → RD for lw/lb; → WR for sw; → RMW_RD for sb; → WB for non-memory ops.
  - RD → WB on ack.
  - WR → WB on ack.
  - RMW_RD → RMW_WR on ack. The read word is latched.
  - RMW_WR → WB on ack.
  - WB → IDLE.
- Byte lanes are big-endian: addr[1:0]=0 selects bits [31:24]; addr[1:0]=3 selects bits [7:0].
- lb: `wb_data_out` = the selected byte, sign-extended to 32 bits.
- lw: `wb_data_out` = `mem_rdata_in`. Address is truncated to a word boundary and `misaligned_out` is flagged.
- sb: the read word has its selected lane replaced by `alu_data_in[7:0]`. The other lanes are unchanged. `mem_we_out`=1 only in RMW_WR.
- sw: `mem_wdata_out` = `alu_data_in`. Same truncation and flagging as lw.
- Non-memory ops: `wb_data_out` = `alu_data_in`. `wb_reg_enable_out` = `alu_reg_enable_in`.
- Loads: `wb_reg_enable_out` = `alu_reg_enable_in`.
- Stores: `wb_reg_enable_out` = 0. `wb_valid_out` still pulses.
- Register 0: `wb_reg_enable_out` is forced to 0 when `wb_reg_num_out`=0.
- Timeout: the counter runs while `mem_req_out`=1 and clears on each ack or state change. On reaching `TIMEOUT` without ack, the FSM goes to WB with `mem_error_out`=1 and `wb_reg_enable_out`=0, and `mem_req_out` drops.
- An ack arriving in the same cycle as the timeout wins; it is a normal completion.
- `mem_ack_in` outside RD/WR/RMW_RD/RMW_WR is ignored.

## Timing
- Accept at cycle T.
- Non-memory op: `wb_valid_out` at T+1 (WB). `ready_out` high again at T+2.
- Memory request is asserted from T+1. Ack may arrive in the same cycle as the request (zero wait).
- lw/lb/sw with zero-wait ack at T+1: `wb_valid_out` at T+2.
- Each wait cycle adds 1 cycle of latency.
- sb with zero-wait acks: read request at T+1, write request at T+2, `wb_valid_out` at T+3.
- `mem_addr_out`, `mem_we_out` and `mem_wdata_out` are registered and stable for the whole time `mem_req_out` is high.
- All wb outputs are registered. They are valid only in the `wb_valid_out` cycle and hold their value otherwise.
- Throughput: at most one instruction every 2 cycles (non-memory).

## Test plan
- Reset mid-RMW: assert `rst_b` in RMW_WR → next cycle `mem_req_out`=0, `ready_out`=1, no `wb_valid_out`.
- lb, addr=0x102, mem word 0x1234_80FF, zero-wait → `wb_data_out`=0xFFFF_FF80 at T+2, reg enable 1, `mem_addr_out`=0x100.
- sb, addr=0x203, data=0xAB, read word 0x1122_3344, acks delayed 3 cycles each → write of 0x1122_33AB with `mem_we_out`=1; `wb_valid_out` with `wb_reg_enable_out`=0.
- lw with addr=0x006, reg 0 destination → `mem_addr_out`=0x004, `misaligned_out`=1, `wb_reg_enable_out`=0.
- Timeout: lw with ack never asserted → `mem_req_out` high for 64 cycles, then `mem_error_out`=1 and `wb_valid_out`=1; ack on cycle 64 instead → normal completion.
- Back-to-back non-memory ops with `valid_in` held high → `wb_valid_out` every 2 cycles; `ready_out` low in WB; no lost or duplicate writebacks.
